// File: rtl/mcu_mem_arbiter_pkg.sv
// Shared definitions for the MCU data-memory arbiter: FSM state encoding and
// the req/ack protocol constants used by the arbiter and its round-robin picker.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_e;

   localparam logic REQ_ACTIVE = 1'b1;
   localparam logic WE_WRITE   = 1'b1;

endpackage

// File: rtl/mcu_mem_arbiter_if.sv
// Requester/memory bus of the MCU memory arbiter. The slave modport is the
// arbiter; the master modport is the requester + memory-macro side.
interface mcu_mem_arbiter_if #(
   parameter int N_REQ = 3,
   parameter int AW    = 8,
   parameter int DW    = 8
);
   logic [N_REQ-1:0]    req;
   logic [N_REQ-1:0]    we;
   logic [N_REQ*AW-1:0] addr;
   logic [N_REQ*DW-1:0] wdata;
   logic [N_REQ-1:0]    gnt;
   logic [N_REQ-1:0]    ack;
   logic [DW-1:0]       rdata;
   logic                err;
   logic                mem_en;
   logic                mem_we;
   logic [AW-1:0]       mem_addr;
   logic [DW-1:0]       mem_wdata;
   logic [DW-1:0]       mem_rdata;

   modport slave (
      input  req, we, addr, wdata, mem_rdata,
      output gnt, ack, rdata, err, mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output req, we, addr, wdata, mem_rdata,
      input  gnt, ack, rdata, err, mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mcu_mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after the
// pointer, wrapping from N_REQ-1 back to 0.
module rr_picker
   import mem_arb_pkg::*;
#(
   parameter int N_REQ = 3,
   parameter int IW    = 2
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [IW-1:0]    i_ptr,
   output logic             o_valid,
   output logic [IW-1:0]    o_owner
);
   int w_idx;

   // Scan from the farthest offset down so the nearest requester wins.
   always_comb begin
      o_valid = 1'b0;
      o_owner = '0;
      w_idx   = 0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         w_idx = (int'(i_ptr) + k) % N_REQ;
         if (i_req[w_idx] == REQ_ACTIVE) begin
            o_valid = 1'b1;
            o_owner = IW'(w_idx);
         end
      end
   end
endmodule

// File: rtl/mcu_mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-port memory among N_REQ
// requesters. Optional address range check: define MEM_ARB_RANGE_CHECK_EN.
module mcu_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int N_REQ     = 3,
   parameter int AW        = 8,
   parameter int DW        = 8,
   parameter int MEM_LAT   = 1,
   parameter int MEM_DEPTH = 256
) (
   input  logic              clk,
   input  logic              rst,
   mcu_mem_arbiter_if.slave  bus
);
   localparam int IW = $clog2(N_REQ);
   localparam int CW = $clog2(MEM_LAT + 1);
`ifdef MEM_ARB_RANGE_CHECK_EN
   localparam bit RANGE_EN = 1'b1;
`else
   localparam bit RANGE_EN = 1'b0;
`endif

   arb_state_e       r_state;
   logic [IW-1:0]    r_ptr;
   logic [IW-1:0]    r_owner;
   logic [CW-1:0]    r_cnt;
   logic [N_REQ-1:0] r_gnt;
   logic [N_REQ-1:0] r_ack;
   logic [DW-1:0]    r_rdata;
   logic             r_err;
   logic             r_mem_en;
   logic             r_mem_we;
   logic [AW-1:0]    r_mem_addr;
   logic [DW-1:0]    r_mem_wdata;

   logic             w_valid;
   logic [IW-1:0]    w_owner;
   logic [AW-1:0]    w_sel_addr;
   logic [DW-1:0]    w_sel_wdata;
   logic             w_oob;

   rr_picker #(.N_REQ(N_REQ), .IW(IW)) u_picker (
      .i_req   (bus.req),
      .i_ptr   (r_ptr),
      .o_valid (w_valid),
      .o_owner (w_owner)
   );

   assign w_sel_addr  = bus.addr[w_owner*AW +: AW];
   assign w_sel_wdata = bus.wdata[w_owner*DW +: DW];
   assign w_oob       = RANGE_EN && (32'(w_sel_addr) >= 32'(MEM_DEPTH));

   function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] idx);
      onehot      = '0;
      onehot[idx] = 1'b1;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_ptr       <= '0;
         r_owner     <= '0;
         r_cnt       <= '0;
         r_gnt       <= '0;
         r_ack       <= '0;
         r_rdata     <= '0;
         r_err       <= 1'b0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_valid) begin
                  r_owner <= w_owner;
                  r_gnt   <= onehot(w_owner);
                  // Out-of-range accesses never touch the memory.
                  if (w_oob) begin
                     r_state <= ST_RESP;
                  end else begin
                     r_state     <= ST_ISSUE;
                     r_mem_en    <= 1'b1;
                     r_mem_we    <= bus.we[w_owner];
                     r_mem_addr  <= w_sel_addr;
                     r_mem_wdata <= w_sel_wdata;
                  end
               end
            end
            ST_ISSUE: begin
               r_mem_en <= 1'b0;
               r_mem_we <= 1'b0;
               if (r_mem_we == WE_WRITE) begin
                  r_state <= ST_RESP;
                  r_ack   <= onehot(r_owner);
               end else begin
                  r_state <= ST_WAIT;
                  r_cnt   <= CW'(MEM_LAT);
               end
            end
            ST_WAIT: begin
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == CW'(1)) begin
                  r_rdata <= bus.mem_rdata;
                  r_ack   <= onehot(r_owner);
                  r_state <= ST_RESP;
               end
            end
            ST_RESP: begin
               // Entered without ack only from the range-error path: pulse it now.
               if (r_ack == '0) begin
                  r_ack <= onehot(r_owner);
                  r_err <= RANGE_EN;
               end else begin
                  r_ack   <= '0;
                  r_gnt   <= '0;
                  r_err   <= 1'b0;
                  r_ptr   <= (r_owner == IW'(N_REQ - 1)) ? '0 : r_owner + 1'b1;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.gnt       = r_gnt;
   assign bus.ack       = r_ack;
   assign bus.rdata     = r_rdata;
   assign bus.err       = RANGE_EN ? r_err : 1'b0;
   assign bus.mem_en    = r_mem_en;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_mcu_mem_arbiter.sv
// Directed + randomized bench for mcu_mem_arbiter with a transaction-level
// reference model (round-robin pointer, memory image, last read data).
module tb_mcu_mem_arbiter;
   localparam int N_REQ     = 3;
   localparam int AW        = 8;
   localparam int DW        = 8;
   localparam int MEM_LAT   = 2;
   localparam int MEM_DEPTH = 200;
`ifdef MEM_ARB_RANGE_CHECK_EN
   localparam bit RANGE_EN = 1'b1;
`else
   localparam bit RANGE_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mcu_mem_arbiter_if #(.N_REQ(N_REQ), .AW(AW), .DW(DW)) bus ();

   mcu_mem_arbiter #(
      .N_REQ(N_REQ), .AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .MEM_DEPTH(MEM_DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Behavioural memory macro: read data appears MEM_LAT cycles after mem_en.
   logic [7:0] mem [256];
   logic [7:0] rd_pipe [MEM_LAT];
   bit         mem_ready = 1'b0;
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7 + 3);
         mem_ready <= 1'b1;
      end else if (bus.mem_en && bus.mem_we) begin
         mem[bus.mem_addr] <= bus.mem_wdata;
      end
      rd_pipe[0] <= (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr] : 8'hXX;
      for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign bus.mem_rdata = rd_pipe[MEM_LAT-1];

   // Reference model state
   logic [7:0] exp_mem [256];
   int         exp_ptr;
   logic [7:0] exp_rdata;
   int         last_owner;
   logic       m_we   [N_REQ];
   logic [7:0] m_addr [N_REQ];
   logic [7:0] m_wd   [N_REQ];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_masters(input logic [N_REQ-1:0] mask);
      bus.req = mask;
      for (int i = 0; i < N_REQ; i++) begin
         bus.we[i]             = m_we[i];
         bus.addr[i*AW +: AW]  = m_addr[i];
         bus.wdata[i*DW +: DW] = m_wd[i];
      end
   endtask

   // One arbitrated access; called at a negedge while the arbiter is idle.
   task automatic txn(input logic [N_REQ-1:0] mask, input bit keep);
      int   own, cyc, pulses, lat;
      bit   got;
      logic err_e;
      drive_masters(mask);
      own = -1;
      for (int k = 0; k < N_REQ; k++)
         if (own < 0 && mask[(exp_ptr + k) % N_REQ]) own = (exp_ptr + k) % N_REQ;
      err_e  = RANGE_EN && (int'(m_addr[own]) >= MEM_DEPTH);
      lat    = (err_e || m_we[own]) ? 2 : 2 + MEM_LAT;
      got    = 1'b0;
      pulses = 0;
      cyc    = 0;
      for (int c = 1; c <= 20 && !got; c++) begin
         @(negedge clk);
         cyc = c;
         if (bus.mem_en) pulses++;
         if (c == 1) begin
            chk("issue_mem_en", bus.mem_en, !err_e);
            chk("issue_gnt", bus.gnt, 1 << own);
            if (!err_e) begin
               chk("issue_mem_we", bus.mem_we, m_we[own]);
               chk("issue_mem_addr", bus.mem_addr, m_addr[own]);
               if (m_we[own]) chk("issue_mem_wdata", bus.mem_wdata, m_wd[own]);
            end
         end
         if (bus.ack != '0) got = 1'b1;
      end
      chk("ack_seen", got, 1);
      chk("ack_owner", bus.ack, 1 << own);
      chk("ack_latency", cyc, lat);
      chk("gnt_at_ack", bus.gnt, 1 << own);
      chk("err", bus.err, err_e);
      chk("mem_en_pulses", pulses, !err_e);
      if (!err_e) begin
         if (m_we[own]) exp_mem[m_addr[own]] = m_wd[own];
         else           exp_rdata = exp_mem[m_addr[own]];
      end
      chk("rdata", bus.rdata, exp_rdata);
      exp_ptr    = (own + 1) % N_REQ;
      last_owner = own;
      if (!keep) bus.req[own] = 1'b0;
      @(negedge clk);
      chk("ack_one_cycle", bus.ack, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int order [6];
      int since [N_REQ];
      order = '{0, 1, 2, 0, 1, 2};
      for (int i = 0; i < 256; i++) exp_mem[i] = 8'(i * 7 + 3);
      for (int i = 0; i < N_REQ; i++) begin
         m_we[i] = 1'b0; m_addr[i] = '0; m_wd[i] = '0; since[i] = 0;
      end
      exp_ptr = 0; exp_rdata = '0; last_owner = -1;
      drive_masters('0);

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_gnt", bus.gnt, 0);
      chk("rst_ack", bus.ack, 0);
      chk("rst_mem_en", bus.mem_en, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_rdata", bus.rdata, 0);
      chk("rst_err", bus.err, 0);
      rst = 1'b1;
      @(negedge clk);

      // Reset mid-operation: outputs clear asynchronously, access abandoned
      m_we[0] = 1'b1; m_addr[0] = 8'h33; m_wd[0] = 8'h5C;
      drive_masters(3'b001);
      @(negedge clk);
      chk("mid_pre_mem_en", bus.mem_en, 1);
      #1 rst = 1'b0;
      #1;
      chk("mid_gnt", bus.gnt, 0);
      chk("mid_mem_en", bus.mem_en, 0);
      chk("mid_mem_we", bus.mem_we, 0);
      chk("mid_mem_addr", bus.mem_addr, 0);
      chk("mid_mem_wdata", bus.mem_wdata, 0);
      @(negedge clk);
      rst = 1'b1;
      drive_masters('0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("idle_gnt", bus.gnt, 0);
         chk("idle_mem_en", bus.mem_en, 0);
         chk("idle_ack", bus.ack, 0);
      end

      // Write by master 0, then read back by master 1
      m_we[0] = 1'b1; m_addr[0] = 8'h10; m_wd[0] = 8'hA5;
      txn(3'b001, 1'b0);
      m_we[1] = 1'b0; m_addr[1] = 8'h10;
      txn(3'b010, 1'b0);
      chk("readback_A5", bus.rdata, 8'hA5);
      m_we[2] = 1'b1; m_addr[2] = 8'h20; m_wd[2] = 8'h3C;
      txn(3'b100, 1'b0);

      // All masters requesting continuously from ptr=0
      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < N_REQ; i++) begin
            m_we[i] = 1'($urandom_range(0, 1));
            m_addr[i] = 8'($urandom_range(0, MEM_DEPTH - 1));
            m_wd[i] = 8'($urandom);
         end
         txn(3'b111, 1'b1);
         chk("rr_order", last_owner, order[k]);
         for (int i = 0; i < N_REQ; i++) since[i] = (i == last_owner) ? 0 : since[i] + 1;
         for (int i = 0; i < N_REQ; i++) chk("rr_wait_bound", since[i] <= N_REQ - 1, 1);
      end
      drive_masters('0);

      // Reset during WAIT of a master-2 read
      m_we[2] = 1'b0; m_addr[2] = 8'h20;
      drive_masters(3'b100);
      @(negedge clk);
      @(negedge clk);
      #1 rst = 1'b0;
      #1;
      chk("wait_rst_gnt", bus.gnt, 0);
      chk("wait_rst_mem_en", bus.mem_en, 0);
      chk("wait_rst_ack", bus.ack, 0);
      chk("wait_rst_rdata", bus.rdata, 0);
      @(negedge clk);
      rst = 1'b1;
      exp_ptr = 0; exp_rdata = '0;
      m_we[0] = 1'b0; m_addr[0] = 8'h10;
      txn(3'b101, 1'b0);
      chk("post_rst_first_owner", last_owner, 0);
      drive_masters('0);

      // Address beyond MEM_DEPTH
      m_we[0] = 1'b0; m_addr[0] = 8'hF0;
      txn(3'b001, 1'b0);
      chk("range_err_flag", bus.err, RANGE_EN);

      // Randomized traffic
      for (int k = 0; k < 40; k++) begin
         logic [N_REQ-1:0] mask;
         mask = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
         for (int i = 0; i < N_REQ; i++) begin
            m_we[i] = 1'($urandom_range(0, 1));
            m_addr[i] = 8'($urandom);
            m_wd[i] = 8'($urandom);
         end
         txn(mask, 1'b0);
         drive_masters('0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
